exec_controller: RTL and testbench

//  Run/step/halt sequencer for the single-cycle CPU core. Generates the core's
//  per-instruction enable pulse in free-run, single-step and syscall-halt modes.

---
 rtl/exec_controller_pkg.sv | 11 +
 rtl/exec_controller_sync_edge.sv | 28 ++
 rtl/exec_controller.sv | 127 ++++++++++++
 tb/tb_exec_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_controller_pkg.sv
// Shared types for the run/step/halt sequencer.
// State encoding used by the controller FSM.
package exec_controller_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } exc_state_t;

endpackage

// File: rtl/exec_controller_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one button.
// The edge output is a single-cycle pulse.
module exec_controller_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic s1;
  logic s2;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      s2_q <= s2;
    end
  end

  assign rise = s2 & ~s2_q;

endmodule

// File: rtl/exec_controller.sv
// Run/step/halt sequencer: issues one core enable per instruction,
// latches syscall display data and counts retired instructions.
module exec_controller
  import exec_controller_pkg::*;
#(
  parameter int unsigned DIV   = 1,
  parameter int unsigned DIV_W = 24,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_go,
  input  logic             btn_step,
  input  logic             cpu_halt,
  input  logic             cpu_display_en,
  input  logic [31:0]      cpu_display,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [31:0]      display,
  output logic [CNT_W-1:0] inst_cnt
);

  logic go_edge;
  logic step_edge;

  exec_controller_sync_edge u_go (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_go),
    .rise  (go_edge)
  );

  exec_controller_sync_edge u_step (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_step),
    .rise  (step_edge)
  );

  exc_state_t       state;
  exc_state_t       state_d;
  logic [DIV_W-1:0] pcnt;
  logic [DIV_W-1:0] pcnt_d;
  logic             pulse_q;
  logic             pulse_d;
  logic             force_q;
  logic             force_d;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= ST_PAUSE;
      pcnt    <= '0;
      pulse_q <= 1'b0;
      force_q <= 1'b0;
    end else begin
      state   <= state_d;
      pcnt    <= pcnt_d;
      pulse_q <= pulse_d;
      force_q <= force_d;
    end
  end

  always_comb begin
    state_d = state;
    pcnt_d  = pcnt;
    pulse_d = 1'b0;
    force_d = 1'b0;
    unique case (state)
      ST_PAUSE: begin
        if (go_edge) begin
          state_d = ST_RUN;
          pcnt_d  = '0;
        end else if (step_edge) begin
          pulse_d = 1'b1;
          force_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (go_edge) begin
          state_d = ST_PAUSE;
          pcnt_d  = '0;
        end else if (pulse_q & cpu_halt & ~force_q) begin
          // Suppressed pulse leaves the PC on the syscall.
          state_d = ST_HALT;
          pcnt_d  = '0;
        end else if (pcnt == DIV_W'(DIV - 1)) begin
          pcnt_d  = '0;
          pulse_d = 1'b1;
        end else begin
          pcnt_d  = pcnt + DIV_W'(1);
        end
      end
      ST_HALT: begin
        if (go_edge) begin
          state_d = ST_RUN;
          pcnt_d  = '0;
          pulse_d = 1'b1;
          force_d = 1'b1;
        end else if (step_edge) begin
          state_d = ST_PAUSE;
          pulse_d = 1'b1;
          force_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_PAUSE;
        pcnt_d  = '0;
      end
    endcase
  end

  assign cpu_en  = pulse_q & (~cpu_halt | force_q);
  assign running = (state == ST_RUN);
  assign halted  = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      display  <= '0;
      inst_cnt <= '0;
    end else begin
      if (cpu_en & cpu_display_en) display <= cpu_display;
      if (cpu_en) inst_cnt <= inst_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench: DUT a (DIV=4, CNT_W=4), DUT b (DIV=1, CNT_W=32),
// both driven from the same button and core inputs.
module tb_exec_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        btn_go = 1'b0;
  logic        btn_step = 1'b0;
  logic        cpu_halt = 1'b0;
  logic        cpu_display_en = 1'b0;
  logic [31:0] cpu_display = '0;

  logic        en_a, run_a, hlt_a;
  logic [31:0] disp_a;
  logic [3:0]  cnt_a;
  logic        en_b, run_b, hlt_b;
  logic [31:0] disp_b;
  logic [31:0] cnt_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exec_controller #(.DIV(4), .DIV_W(8), .CNT_W(4)) dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_go         (btn_go),
    .btn_step       (btn_step),
    .cpu_halt       (cpu_halt),
    .cpu_display_en (cpu_display_en),
    .cpu_display    (cpu_display),
    .cpu_en         (en_a),
    .running        (run_a),
    .halted         (hlt_a),
    .display        (disp_a),
    .inst_cnt       (cnt_a)
  );

  exec_controller #(.DIV(1), .DIV_W(24), .CNT_W(32)) dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_go         (btn_go),
    .btn_step       (btn_step),
    .cpu_halt       (cpu_halt),
    .cpu_display_en (cpu_display_en),
    .cpu_display    (cpu_display),
    .cpu_en         (en_b),
    .running        (run_b),
    .halted         (hlt_b),
    .display        (disp_b),
    .inst_cnt       (cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    btn_go   = 1'b0;
    btn_step = 1'b0;
    cpu_halt = 1'b0;
    rst_n    = 1'b1;
    tick();
    rst_n    = 1'b0;
  endtask

  // Button held for three edges: its edge acts on the third.
  task automatic press_go();
    btn_go = 1'b1;
    tick(3);
    btn_go = 1'b0;
  endtask

  task automatic press_step();
    btn_step = 1'b1;
    tick(3);
    btn_step = 1'b0;
  endtask

  initial begin
    // 1: reset state and single step
    do_reset();
    check("rst_en_a", 32'(en_a), 32'd0);
    check("rst_run_a", 32'(run_a), 32'd0);
    check("rst_hlt_a", 32'(hlt_a), 32'd0);
    check("rst_disp_a", disp_a, 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_cnt_b", cnt_b, 32'd0);
    btn_step = 1'b1;
    tick();
    check("step_e0", 32'(en_a), 32'd0);
    tick();
    check("step_e1", 32'(en_a), 32'd0);
    tick();
    check("step_e2_a", 32'(en_a), 32'd1);
    check("step_e2_b", 32'(en_b), 32'd1);
    btn_step = 1'b0;
    tick();
    check("step_e3", 32'(en_a), 32'd0);
    check("step_cnt_a", 32'(cnt_a), 32'd1);
    check("step_cnt_b", cnt_b, 32'd1);
    check("step_run", 32'(run_a), 32'd0);
    tick(3);
    check("step_once", 32'(cnt_a), 32'd1);

    // 2: free run, DIV=4 vs DIV=1, then pause
    do_reset();
    press_go();
    check("go_run_a", 32'(run_a), 32'd1);
    check("go_run_b", 32'(run_b), 32'd1);
    check("go_en_a", 32'(en_a), 32'd0);
    for (int i = 1; i <= 40; i++) begin
      tick();
      check($sformatf("run_en_a_%0d", i), 32'(en_a), 32'((i % 4) == 0));
      check($sformatf("run_en_b_%0d", i), 32'(en_b), 32'd1);
    end
    press_go();
    check("pause_run_a", 32'(run_a), 32'd0);
    check("pause_cnt_a", 32'(cnt_a), 32'd10);
    check("pause_cnt_b", cnt_b, 32'd42);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pause_en_a", 32'(en_a), 32'd0);
      check("pause_en_b", 32'(en_b), 32'd0);
    end
    check("pause_cnt_a2", 32'(cnt_a), 32'd10);

    // 3: halt on syscall, resume steps over it
    do_reset();
    press_go();
    cpu_halt = 1'b1;
    tick(4);
    check("halt_gate", 32'(en_a), 32'd0);
    tick();
    check("halt_st_a", 32'(hlt_a), 32'd1);
    check("halt_run_a", 32'(run_a), 32'd0);
    check("halt_st_b", 32'(hlt_b), 32'd1);
    tick(4);
    check("halt_cnt_a", 32'(cnt_a), 32'd0);
    check("halt_cnt_b", cnt_b, 32'd0);
    check("halt_en_a", 32'(en_a), 32'd0);
    press_go();
    check("resume_en_a", 32'(en_a), 32'd1);
    check("resume_en_b", 32'(en_b), 32'd1);
    check("resume_run_a", 32'(run_a), 32'd1);
    tick();
    check("resume_en_a1", 32'(en_a), 32'd0);
    check("resume_cnt_a", 32'(cnt_a), 32'd1);
    check("resume_still_run", 32'(run_a), 32'd1);
    cpu_halt = 1'b0;

    // 4: display latch
    do_reset();
    cpu_display_en = 1'b1;
    cpu_display    = 32'hDEADBEEF;
    tick(3);
    check("disp_no_en", disp_a, 32'd0);
    press_step();
    check("disp_step_en", 32'(en_a), 32'd1);
    tick();
    check("disp_latch", disp_a, 32'hDEADBEEF);
    cpu_display = 32'h12345678;
    tick(4);
    check("disp_hold", disp_a, 32'hDEADBEEF);
    cpu_display_en = 1'b0;
    press_step();
    tick();
    check("disp_no_den", disp_a, 32'hDEADBEEF);
    check("disp_cnt", 32'(cnt_a), 32'd2);

    // 5: go and step together -> go wins
    do_reset();
    btn_go   = 1'b1;
    btn_step = 1'b1;
    tick(3);
    btn_go   = 1'b0;
    btn_step = 1'b0;
    check("both_run", 32'(run_a), 32'd1);
    check("both_no_step", 32'(en_a), 32'd0);
    tick(3);
    check("both_cnt", 32'(cnt_a), 32'd0);
    tick();
    check("both_first", 32'(en_a), 32'd1);

    // 6: counter wrap, then reset mid-pulse
    do_reset();
    press_go();
    tick(61);
    check("wrap_pre", 32'(cnt_a), 32'd15);
    tick(4);
    check("wrap_zero", 32'(cnt_a), 32'd0);
    tick(3);
    check("mid_pulse", 32'(en_a), 32'd1);
    rst_n = 1'b1;
    tick();
    check("rst_pulse_en", 32'(en_a), 32'd0);
    check("rst_pulse_run", 32'(run_a), 32'd0);
    check("rst_pulse_hlt", 32'(hlt_a), 32'd0);
    rst_n = 1'b0;
    tick(6);
    check("rst_stay_en", 32'(en_a), 32'd0);
    check("rst_stay_cnt", 32'(cnt_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
